signed_seq_multiplier: RTL
==========================

# signed_seq_multiplier

Parametrised sequential shift-add multiplier with per-operand signed/unsigned selection and a Start/Busy/Done handshake. It is the multi-cycle, width-generic successor to the team's 4-bit combinational sign-correcting multiplier. The datapath stays narrow: one WIDTH-bit adder plus a 2*WIDTH-bit shift register. It sits in the arithmetic datapath and is driven by a controller that issues one product request at a time.

## Interface
- WIDTH, 8, operand width in bits (≥2); product is 2*WIDTH bits
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  request; sampled only in IDLE
- inputA  in  WIDTH  multiplicand
- inputB  in  WIDTH  multiplier
- SignA  in  1  1: inputA is two's complement; 0: unsigned
- SignB  in  1  1: inputB is two's complement; 0: unsigned
- Busy  out  1  high while state ≠ IDLE
- Done  out  1  one-cycle pulse; Product valid
- Product  out  2*WIDTH  result; two's complement if SignA|SignB, else unsigned
- ProductSigned  out  1  registered SignA|SignB of the captured request

## Operation
- States: IDLE, RUN, FIX.
- IDLE, Start=1: capture operands and form magnitudes.
  - magA = (SignA & inputA[MSB]) ? −inputA : inputA, as a WIDTH-bit unsigned value; same for magB.
  - −2^(WIDTH−1) maps to magnitude 2^(WIDTH−1), which fits exactly.
  - Latch neg = (SignA & inputA[MSB]) ^ (SignB & inputB[MSB]) and ProductSigned.
  - Clear accumulator; counter = WIDTH; go to RUN.
- RUN, one iteration per cycle:
  - If acc[0]=1, add magA into acc[2W−1:W] with carry out.
  - Shift {carry, acc} right by 1.
  - Decrement counter; at 0, go to FIX.
- FIX:
  - Product ← neg ? (~acc + 1) : acc.
  - Done ← 1; go to IDLE.
- Product holds its value until the next FIX.
- Width rules: all four sign modes fit in 2*WIDTH bits.
  - Signed×unsigned minimum: −2^(W−1)·(2^W−1).
  - Unsigned maximum: (2^W−1)^2.
  - A zero magnitude with neg=1 yields 0, never a negative zero.
- Start while Busy=1 is ignored: no queueing, and captured operands are unaffected.
- Operand inputs are only sampled on the accepting edge and may change freely afterwards.

## Timing
- Reset asserted (any time, including mid-RUN):
  - Immediately: state=IDLE, Busy=0, Done=0, Product=0, ProductSigned=0, counter=0, acc=0.
  - The in-flight request is discarded.
  - The first Start is accepted on the first rising edge after deassertion.
- Start accepted at edge k:
  - Busy=1 from after edge k until edge k+WIDTH+1.
  - RUN occupies edges k+1 … k+WIDTH.
  - FIX executes at edge k+WIDTH+1, asserting Done and updating Product.
- Latency: Done is high in the cycle following edge k+WIDTH+1, for exactly one cycle.
- Throughput: one product per WIDTH+2 cycles.
- Back-to-back: Start held high during the Done cycle is accepted at that edge, because state is IDLE.
- Done and Busy are never high together. Busy=0 in the Done cycle.

## Test plan
- WIDTH=4, SignA=SignB=1, A=4'b1000, B=4'b1000 -> Product=8'h40 (+64), ProductSigned=1. Done exactly 6 cycles after the Start edge.
- WIDTH=4, SignA=SignB=0, A=4'hF, B=4'hF -> Product=8'hE1 (225), ProductSigned=0. Also A=4'hF signed, B=4'hF unsigned -> 8'hF1 (−15).
- WIDTH=4, signed A=4'b0111 (+7), B=4'b1000 (−8) -> 8'hC8 (−56). A=0, B=4'b1101 (−3) signed -> 8'h00.
- WIDTH=8, Start held high continuously, operand pairs (−128·−128, 127·−1, 255u·255u) -> 16'h4000, 16'hFF81, 16'hFE01. Done pulses every 10 cycles; Start ignored while Busy.
- Mid-operation reset:
  - Reset low for one cycle during RUN -> all outputs 0 immediately, no Done pulse.
  - Next request (3·5 unsigned) -> 15 with normal latency.
- Randomised sweep at WIDTH=5 and 8: all sign modes, including ±2^(W−1) and 0 -> Product matches the reference model. Operands changed during RUN do not alter the result.

Source files
------------

// File: rtl/signed_seq_multiplier.sv
// Sequential shift-add multiplier with per-operand signed/unsigned selection.
// Magnitudes are multiplied over WIDTH cycles; the sign is applied in a final fix-up cycle.
`timescale 1ns/1ps

module signed_seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [WIDTH-1:0]     inputA,
    input  logic [WIDTH-1:0]     inputB,
    input  logic                 SignA,
    input  logic                 SignB,
    output logic                 Busy,
    output logic                 Done,
    output logic [2*WIDTH-1:0]   Product,
    output logic                 ProductSigned
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mag_a_q, mag_a_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 psig_q, psig_d;
    logic                 done_q, done_d;

    logic                 neg_a, neg_b;
    logic [WIDTH-1:0]     mag_a_in, mag_b_in;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH:0]     shifted;

    // NOTE: async active-low reset clears every flop, including the datapath,
    // so an aborted request leaves no residue in Product or the accumulator.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            mag_a_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
            psig_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            state_q   <= state_d;
            mag_a_q   <= mag_a_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            product_q <= product_d;
            psig_q    <= psig_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (Start) state_d = RUN;
            RUN:     if (cnt_q == CW'(1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        // NOTE: every target gets a hold default first, so no latches are inferred.
        mag_a_d   = mag_a_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        product_d = product_q;
        psig_d    = psig_q;
        done_d    = (state_q == FIX);

        neg_a    = SignA & inputA[WIDTH-1];
        neg_b    = SignB & inputB[WIDTH-1];
        mag_a_in = neg_a ? (~inputA + WIDTH'(1)) : inputA;
        mag_b_in = neg_b ? (~inputB + WIDTH'(1)) : inputB;

        // Multiplier bits sit in the low half and are consumed LSB-first.
        sum     = acc_q[0] ? ({1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mag_a_q})
                           : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        shifted = {sum, acc_q[WIDTH-1:0]};

        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    mag_a_d = mag_a_in;
                    acc_d   = {{WIDTH{1'b0}}, mag_b_in};
                    cnt_d   = CW'(WIDTH);
                    neg_d   = neg_a ^ neg_b;
                    psig_d  = SignA | SignB;
                end
            end
            RUN: begin
                acc_d = shifted[2*WIDTH:1];
                cnt_d = cnt_q - CW'(1);
            end
            FIX: begin
                // Negating a zero magnitude wraps back to zero.
                product_d = neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        Busy          = (state_q != IDLE);
        Done          = done_q;
        Product       = product_q;
        ProductSigned = psig_q;
    end

endmodule
